// File: rtl/hier_icache_flush_sequencer.sv
// Maintenance command sequencer for the hierarchical icache: runs one command
// at a time, first across the shared banks, then across the private caches.
module hier_icache_flush_sequencer #(
    parameter int unsigned NB_CACHE_BANKS = 4,
    parameter int unsigned NB_CORES       = 9,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [2:0]                cmd_op_i,
    input  logic [NB_CORES-1:0]       cmd_core_mask_i,
    input  logic [31:0]               cmd_addr_i,
    output logic                      rsp_valid_o,
    output logic                      rsp_error_o,
    output logic                      busy_o,
    output logic [NB_CACHE_BANKS-1:0] main_enable_req_o,
    input  logic [NB_CACHE_BANKS-1:0] main_enable_ack_i,
    output logic [NB_CACHE_BANKS-1:0] main_disable_req_o,
    input  logic [NB_CACHE_BANKS-1:0] main_disable_ack_i,
    output logic [NB_CACHE_BANKS-1:0] main_flush_req_o,
    input  logic [NB_CACHE_BANKS-1:0] main_flush_ack_i,
    output logic [NB_CACHE_BANKS-1:0] main_sel_flush_req_o,
    input  logic [NB_CACHE_BANKS-1:0] main_sel_flush_ack_i,
    output logic [31:0]               main_sel_flush_addr_o,
    output logic [NB_CORES-1:0]       pri_bypass_req_o,
    input  logic [NB_CORES-1:0]       pri_bypass_ack_i,
    output logic [NB_CORES-1:0]       pri_flush_req_o,
    input  logic [NB_CORES-1:0]       pri_flush_ack_i,
    output logic [NB_CORES-1:0]       pri_sel_flush_req_o,
    input  logic [NB_CORES-1:0]       pri_sel_flush_ack_i,
    output logic [31:0]               pri_sel_flush_addr_o
);

    typedef enum logic [1:0] {S_IDLE, S_MAIN, S_PRI, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_ENABLE    = 3'd0,
        OP_DISABLE   = 3'd1,
        OP_FLUSH     = 3'd2,
        OP_SEL_FLUSH = 3'd3,
        OP_BYPASS    = 3'd4
    } op_e;

    localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_e                    state_q, state_d;
    logic [2:0]                op_q, op_d;
    logic [NB_CORES-1:0]       mask_q, mask_d;
    logic [31:0]               addr_q, addr_d;
    logic [NB_CACHE_BANKS-1:0] main_pend_q, main_pend_d;
    logic [NB_CORES-1:0]       pri_pend_q, pri_pend_d;
    logic                      err_q, err_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [NB_CACHE_BANKS-1:0] main_ack;
    logic [NB_CORES-1:0]       pri_ack;
    logic                      timeout_hit;

    // Only the ack family that matches the latched op can clear pending bits.
    always_comb begin
        main_ack = '0;
        pri_ack  = '0;
        case (op_q)
            OP_ENABLE:    main_ack = main_enable_ack_i;
            OP_DISABLE:   main_ack = main_disable_ack_i;
            OP_FLUSH: begin
                main_ack = main_flush_ack_i;
                pri_ack  = pri_flush_ack_i;
            end
            OP_SEL_FLUSH: begin
                main_ack = main_sel_flush_ack_i;
                pri_ack  = pri_sel_flush_ack_i;
            end
            OP_BYPASS:    pri_ack = pri_bypass_ack_i;
            default: begin
                main_ack = '0;
                pri_ack  = '0;
            end
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

    // Next-state logic: command latch, per-phase pending sets and timeout.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        err_d       = err_q;
        cnt_d       = cnt_q + CW'(1);
        main_pend_d = main_pend_q & ~main_ack;
        pri_pend_d  = pri_pend_q & ~pri_ack;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cmd_valid_i) begin
                    op_d   = cmd_op_i;
                    mask_d = cmd_core_mask_i;
                    addr_d = cmd_addr_i;
                    case (cmd_op_i)
                        OP_ENABLE, OP_DISABLE, OP_FLUSH, OP_SEL_FLUSH: begin
                            main_pend_d = '1;
                            state_d     = S_MAIN;
                        end
                        OP_BYPASS: begin
                            pri_pend_d = cmd_core_mask_i;
                            state_d    = (|cmd_core_mask_i) ? S_PRI : S_DONE;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_MAIN: begin
                if (main_pend_d == '0) begin
                    cnt_d = '0;
                    if (op_q == OP_FLUSH || op_q == OP_SEL_FLUSH) begin
                        pri_pend_d = mask_q;
                        state_d    = (|mask_q) ? S_PRI : S_DONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout_hit) begin
                    main_pend_d = '0;
                    err_d       = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_PRI: begin
                if (pri_pend_d == '0) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    pri_pend_d = '0;
                    err_d      = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            mask_q      <= '0;
            addr_q      <= '0;
            main_pend_q <= '0;
            pri_pend_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            main_pend_q <= main_pend_d;
            pri_pend_q  <= pri_pend_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outputs decode registers only; no input reaches an output combinationally.
    assign cmd_ready_o           = (state_q == S_IDLE);
    assign busy_o                = (state_q != S_IDLE);
    assign rsp_valid_o           = (state_q == S_DONE);
    assign rsp_error_o           = (state_q == S_DONE) && err_q;
    assign main_enable_req_o     = main_pend_q & {NB_CACHE_BANKS{op_q == OP_ENABLE}};
    assign main_disable_req_o    = main_pend_q & {NB_CACHE_BANKS{op_q == OP_DISABLE}};
    assign main_flush_req_o      = main_pend_q & {NB_CACHE_BANKS{op_q == OP_FLUSH}};
    assign main_sel_flush_req_o  = main_pend_q & {NB_CACHE_BANKS{op_q == OP_SEL_FLUSH}};
    assign pri_bypass_req_o      = pri_pend_q & {NB_CORES{op_q == OP_BYPASS}};
    assign pri_flush_req_o       = pri_pend_q & {NB_CORES{op_q == OP_FLUSH}};
    assign pri_sel_flush_req_o   = pri_pend_q & {NB_CORES{op_q == OP_SEL_FLUSH}};
    assign main_sel_flush_addr_o = addr_q;
    assign pri_sel_flush_addr_o  = addr_q;

endmodule
